// File: rtl/mag_pkg.sv
// Shared constants and types for the magnitude window averager.
// Default geometry: 8-bit samples, 8-deep window (WIN_LOG2 = 3).
// SUM_W is the accumulator width that can never overflow for the default geometry.
package mag_pkg;

  localparam int DEF_DW       = 8;
  localparam int DEF_WIN_LOG2 = 3;
  localparam int SUM_W        = DEF_DW + DEF_WIN_LOG2;

  // Hysteresis alarm states; alarm output is high exactly in ALARM.
  typedef enum logic {
    CLEAR = 1'b0,
    ALARM = 1'b1
  } alarm_st_e;

endpackage

// File: rtl/mag_win_ram.sv
// Ring buffer of the last 2^WIN_LOG2 samples, plus write pointer and fill count.
// Write is registered; o_rdat is an asynchronous read of the slot about to be overwritten.
// No backpressure: one write per cycle whenever i_we is high.
module mag_win_ram
  import mag_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [DW-1:0] i_wdat,
  output logic [DW-1:0] o_rdat,
  output logic          o_full
);

  localparam int                N       = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2:0] CNT_MAX = (WIN_LOG2 + 1)'(N);

  logic [DW-1:0]       r_mem [N];
  logic [WIN_LOG2-1:0] r_wr_ptr;
  logic [WIN_LOG2:0]   r_count;
  logic                r_full;

  // The slot at the write pointer holds the oldest sample once the window is full.
  assign o_rdat = r_mem[r_wr_ptr];
  assign o_full = r_full;

  // Sample storage; contents are only trusted where the fill count says so, so no reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[r_wr_ptr] <= i_wdat;
    end
  end

  // Write pointer wraps naturally; count saturates at N and drives full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else if (i_we) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (!r_full) begin
        r_count <= r_count + 1'b1;
        r_full  <= (r_count == (CNT_MAX - 1'b1));
      end
    end
  end

endmodule

// File: rtl/mag_window_avg.sv
// Sliding-window moving average, peak hold and hysteresis alarm on magnitude samples.
// Latency 2 edges from accepted sample to avg_out/avg_valid; full throughput, no backpressure.
// Optional MAG_AVG_ROUND_EN: round-half-up average instead of truncation (saturating).
module mag_window_avg
  import mag_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_mag,
  input  logic [DW-1:0] thresh_hi,
  input  logic [DW-1:0] thresh_lo,
  output logic [DW-1:0] avg_out,
  output logic          avg_valid,
  output logic [DW-1:0] peak_out,
  output logic          alarm,
  output logic          full
);

  localparam int SW = DW + WIN_LOG2;

  logic          w_accept;
  logic          w_clr;
  logic          w_fire;
  logic          w_full;
  logic [DW-1:0] w_oldest_raw;
  logic [DW-1:0] w_oldest;
  logic [DW-1:0] w_avg_next;

  logic [SW-1:0] r_sum;
  logic          r_pend;
  logic [DW-1:0] r_avg;
  logic          r_avg_vld;
  logic [DW-1:0] r_peak;
  logic          r_alarm;
  alarm_st_e     r_state;

  // clr wins over a simultaneous sample; ena low freezes everything.
  assign w_accept = ena & ~clr & in_valid;
  assign w_clr    = ena & clr;
  // Second-stage update owed to the sample accepted on the previous enabled edge.
  assign w_fire   = ena & ~clr & r_pend;
  // Until the window is full nothing is evicted: missing entries count as zero.
  assign w_oldest = w_full ? w_oldest_raw : '0;

  mag_win_ram #(
    .DW       (DW),
    .WIN_LOG2 (WIN_LOG2)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_we   (w_accept),
    .i_wdat (in_mag),
    .o_rdat (w_oldest_raw),
    .o_full (w_full)
  );

`ifdef MAG_AVG_ROUND_EN
  // One extra bit so adding half an LSB cannot wrap; clamp to the output range.
  logic [SW:0] w_rnd_sum;
  logic [SW:0] w_rnd_shift;
  assign w_rnd_sum   = {1'b0, r_sum} + (SW + 1)'(1 << (WIN_LOG2 - 1));
  assign w_rnd_shift = w_rnd_sum >> WIN_LOG2;
  assign w_avg_next  = (w_rnd_shift > (SW + 1)'({DW{1'b1}})) ? {DW{1'b1}}
                                                             : w_rnd_shift[DW-1:0];
`else
  // Truncating divide by the window depth.
  assign w_avg_next = DW'(r_sum >> WIN_LOG2);
`endif

  // Running window sum: add the new sample, drop the one it overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_clr) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + SW'(in_mag) - SW'(w_oldest);
    end
  end

  // Peak hold over every accepted sample since reset or clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (w_clr) begin
      r_peak <= '0;
    end else if (w_accept && (in_mag > r_peak)) begin
      r_peak <= in_mag;
    end
  end

  // Average stage: publish sum/N one edge after the sum moved; valid only from a full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= 1'b0;
      r_avg     <= '0;
      r_avg_vld <= 1'b0;
    end else if (!ena) begin
      r_avg_vld <= 1'b0;
    end else if (clr) begin
      r_pend    <= 1'b0;
      r_avg     <= '0;
      r_avg_vld <= 1'b0;
    end else begin
      r_pend    <= in_valid;
      r_avg_vld <= r_pend & w_full;
      if (r_pend) begin
        r_avg <= w_avg_next;
      end
    end
  end

  // Hysteresis alarm, judged on the average being published this edge; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_alarm <= 1'b0;
    end else if (w_clr) begin
      r_state <= CLEAR;
      r_alarm <= 1'b0;
    end else if (w_fire && w_full) begin
      case (r_state)
        CLEAR: begin
          if (w_avg_next >= thresh_hi) begin
            r_state <= ALARM;
            r_alarm <= 1'b1;
          end
        end
        ALARM: begin
          if ((w_avg_next < thresh_hi) && (w_avg_next <= thresh_lo)) begin
            r_state <= CLEAR;
            r_alarm <= 1'b0;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_alarm <= 1'b0;
        end
      endcase
    end
  end

  assign avg_out   = r_avg;
  assign avg_valid = r_avg_vld;
  assign peak_out  = r_peak;
  assign alarm     = r_alarm;
  assign full      = w_full;

endmodule
